tcm_mem_port_ctrl: RTL and testbench

Request/response front end for one port of the dual-port TCM RAM. It accepts valid/accept memory requests from a core master (instruction fetch or LSU) and drives the RAM port's word address, write data and byte write enables. It also captures the RAM's registered read data and returns it through a 2-entry response buffer with valid/ready backpressure. One instance sits directly upstream of each RAM port.

---
 rtl/tcm_mem_port_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_tcm_mem_port_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcm_mem_port_ctrl.sv
// ============================================================================
// tcm_mem_port_ctrl
// ----------------------------------------------------------------------------
// Request/response front end for one port of the dual-port TCM RAM.
//
// A core master (instruction fetch or LSU) issues valid/accept requests. The
// block drives the RAM port's word address, write data and byte write enables
// directly from the request. It then captures the RAM's registered read data
// one cycle later and returns it through a 2-entry response FIFO with
// valid/ready backpressure. Every request, read or write, produces exactly one
// response, so responses match requests 1:1 and in order.
//
// Request-to-response latency is 2 cycles. A fire at edge N is sampled by the
// RAM at N. Read data is valid during cycle N+1 and is pushed at edge N+1, so
// resp_valid_o rises in cycle N+2.
//
// Optional feature (compile-time macro):
//   TCM_PORT_RANGE_CHECK_EN
//     When defined, a request with address bits above the RAM range set is
//     still accepted, but it never writes the RAM. Its response carries
//     resp_error_o = 1 and rdata = 0.
//     When undefined, the upper address bits alias into the RAM and
//     resp_error_o is tied to 0.
//
// Parameters:
//   ADDR_WIDTH     RAM word-address width (must match the RAM instance)
//
// Ports:
//   clk_i          clock, shared with the attached RAM port
//   rst_i          asynchronous active-low reset
//   req_valid_i    request present
//   req_addr_i     byte address; [ADDR_WIDTH+1:2] selects the word
//   req_wdata_i    write data
//   req_wr_i       byte write strobes; 4'b0000 = read
//   req_accept_o   request taken when high together with req_valid_i
//   resp_valid_o   response present (head of response FIFO)
//   resp_ready_i   master takes the response
//   resp_rdata_o   read data; 0 for write acknowledges and error responses
//   resp_error_o   range error flag
//   ram_addr_o     RAM word address
//   ram_data_o     RAM write data
//   ram_wr_o       RAM byte write enables
//   ram_data_i     RAM registered read data
// ============================================================================
module tcm_mem_port_ctrl #(
    parameter int ADDR_WIDTH = 23
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  req_valid_i,
    input  logic [31:0]           req_addr_i,
    input  logic [31:0]           req_wdata_i,
    input  logic [3:0]            req_wr_i,
    output logic                  req_accept_o,

    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic [31:0]           resp_rdata_o,
    output logic                  resp_error_o,

    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic [31:0]           ram_data_o,
    output logic [3:0]            ram_wr_o,
    input  logic [31:0]           ram_data_i
);

    localparam int FIFO_DEPTH = 2;

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    logic                         w_fire;
    logic                         w_pop;
    logic                         w_push;
    logic                         w_range_err;
    logic                         w_zero_rdata;
    logic [31:0]                  w_push_data;
    logic [2:0]                   w_credit_used;
    logic                         w_unused_addr;

    logic                         r_inflight_q;
    logic                         r_inflight_wr_q;
    logic                         r_inflight_err_q;

    logic [1:0]                   r_count_q;
    logic                         r_wr_ptr_q;
    logic                         r_rd_ptr_q;

    logic [FIFO_DEPTH-1:0][31:0]  w_entry_data;
    logic [FIFO_DEPTH-1:0]        w_entry_err;

    // The address LSBs are never used. In the default build the upper
    // address bits are not used either.
    assign w_unused_addr = ^req_addr_i;

    // ------------------------------------------------------------------------
    // Range check
    // ------------------------------------------------------------------------
`ifdef TCM_PORT_RANGE_CHECK_EN
    // A shift is used instead of a slice so the check stays legal for any
    // ADDR_WIDTH. At ADDR_WIDTH = 30 the result is constant 0.
    assign w_range_err = ((req_addr_i >> (ADDR_WIDTH + 2)) != 32'd0);
`else
    assign w_range_err = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Handshakes and credit
    // ------------------------------------------------------------------------
    assign resp_valid_o = (r_count_q != 2'd0);
    assign w_pop        = resp_valid_o & resp_ready_i;
    assign w_push       = r_inflight_q;

    // The credits in use are the FIFO occupancy plus the request in the RAM
    // pipeline. A pop in this cycle frees one credit immediately, so accept
    // can reassert in the pop cycle itself. The FIFO therefore never
    // overflows. w_pop implies r_count_q >= 1, so the sum never goes below 0.
    assign w_credit_used = {1'b0, r_count_q} + {2'b00, r_inflight_q} - {2'b00, w_pop};
    assign req_accept_o  = (w_credit_used < 3'd2);
    assign w_fire        = req_valid_i & req_accept_o;

    // ------------------------------------------------------------------------
    // RAM port drive
    // ------------------------------------------------------------------------
    // Address and data pass through unconditionally. Only the write enables
    // are qualified. They are also held low while reset is asserted, so a
    // request presented during reset cannot corrupt the RAM.
    assign ram_addr_o = req_addr_i[ADDR_WIDTH+1:2];
    assign ram_data_o = req_wdata_i;
    assign ram_wr_o   = (w_fire && rst_i && !w_range_err) ? req_wr_i : 4'b0000;

    // ------------------------------------------------------------------------
    // Issue stage: one request can be in the RAM pipeline at a time.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_inflight_q    <= 1'b0;
            r_inflight_wr_q <= 1'b0;
        end else begin
            r_inflight_q    <= w_fire;
            r_inflight_wr_q <= w_fire && (req_wr_i != 4'b0000);
        end
    end

`ifdef TCM_PORT_RANGE_CHECK_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_inflight_err_q <= 1'b0;
        end else begin
            r_inflight_err_q <= w_fire && w_range_err;
        end
    end
`else
    assign r_inflight_err_q = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Capture stage
    // ------------------------------------------------------------------------
    // Write acknowledges and error responses carry zero data. Only a real
    // read returns the RAM output.
    assign w_zero_rdata = r_inflight_wr_q | r_inflight_err_q;
    assign w_push_data  = w_zero_rdata ? 32'd0 : ram_data_i;

    // ------------------------------------------------------------------------
    // Response FIFO: 2-entry circular buffer with 1-bit pointers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_count_q  <= 2'd0;
            r_wr_ptr_q <= 1'b0;
            r_rd_ptr_q <= 1'b0;
        end else begin
            // A simultaneous push and pop leaves the count unchanged, and
            // both pointers advance.
            r_count_q <= r_count_q + {1'b0, w_push} - {1'b0, w_pop};
            if (w_push) begin
                r_wr_ptr_q <= ~r_wr_ptr_q;
            end
            if (w_pop) begin
                r_rd_ptr_q <= ~r_rd_ptr_q;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
            localparam logic ENTRY_IDX = 1'(gi);

            logic [31:0] r_data_q;

            // Entries reset to zero so the head reads 0 out of reset.
            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i) begin
                    r_data_q <= 32'd0;
                end else if (w_push && (r_wr_ptr_q == ENTRY_IDX)) begin
                    r_data_q <= w_push_data;
                end
            end
            assign w_entry_data[gi] = r_data_q;

`ifdef TCM_PORT_RANGE_CHECK_EN
            logic r_err_q;

            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i) begin
                    r_err_q <= 1'b0;
                end else if (w_push && (r_wr_ptr_q == ENTRY_IDX)) begin
                    r_err_q <= r_inflight_err_q;
                end
            end
            assign w_entry_err[gi] = r_err_q;
`else
            assign w_entry_err[gi] = 1'b0;
`endif
        end
    endgenerate

    // The head entry drives the response. It stays put until it is popped,
    // so the outputs remain stable under backpressure.
    assign resp_rdata_o = w_entry_data[r_rd_ptr_q];

`ifdef TCM_PORT_RANGE_CHECK_EN
    assign resp_error_o = w_entry_err[r_rd_ptr_q];
`else
    assign resp_error_o = 1'b0;
`endif

endmodule

// File: tb/tb_tcm_mem_port_ctrl.sv
// ============================================================================
// tb_tcm_mem_port_ctrl
// ----------------------------------------------------------------------------
// Bench for tcm_mem_port_ctrl.
//
// A behavioural read-first RAM with a registered output sits behind the DUT.
// Each word is initialised to 0xC0DE0000 | word_index while reset is low.
//
// A per-cycle vector table drives the request and ready inputs. It checks
// accept, response valid/data/error, RAM write enables and RAM address.
// Hand-written sequences cover the reset values and a reset that lands on an
// in-flight read.
//
// Works with or without TCM_PORT_RANGE_CHECK_EN.
// ============================================================================
module tb_tcm_mem_port_ctrl;

    localparam int AW = 23;

`ifdef TCM_PORT_RANGE_CHECK_EN
    localparam bit RANGE_CHK = 1'b1;
`else
    localparam bit RANGE_CHK = 1'b0;
`endif

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          req_valid_i;
    logic [31:0]   req_addr_i;
    logic [31:0]   req_wdata_i;
    logic [3:0]    req_wr_i;
    logic          req_accept_o;
    logic          resp_valid_o;
    logic          resp_ready_i;
    logic [31:0]   resp_rdata_o;
    logic          resp_error_o;
    logic [AW-1:0] ram_addr_o;
    logic [31:0]   ram_data_o;
    logic [3:0]    ram_wr_o;
    logic [31:0]   ram_data_i;

    int n_checks = 0;
    int n_errors = 0;

    tcm_mem_port_ctrl #(.ADDR_WIDTH(AW)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_addr_i   (req_addr_i),
        .req_wdata_i  (req_wdata_i),
        .req_wr_i     (req_wr_i),
        .req_accept_o (req_accept_o),
        .resp_valid_o (resp_valid_o),
        .resp_ready_i (resp_ready_i),
        .resp_rdata_o (resp_rdata_o),
        .resp_error_o (resp_error_o),
        .ram_addr_o   (ram_addr_o),
        .ram_data_o   (ram_data_o),
        .ram_wr_o     (ram_wr_o),
        .ram_data_i   (ram_data_i)
    );

    always #5 clk_i = ~clk_i;

    // ------------------------------------------------------------------------
    // Behavioural RAM: read-first, registered output.
    // Only the low 15 word-address bits are kept.
    // ------------------------------------------------------------------------
    logic [31:0] mem [0:32767];

    always @(posedge clk_i) begin
        if (!rst_i) begin
            for (int i = 0; i < 32768; i++) begin
                mem[i] <= 32'hC0DE_0000 | i;
            end
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (ram_wr_o[b]) begin
                    mem[ram_addr_o[14:0]][8*b +: 8] <= ram_data_o[8*b +: 8];
                end
            end
        end
        ram_data_i <= mem[ram_addr_o[14:0]];
    end

    // ------------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------------
    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s (step %0d): got %08h, expected %08h", name, idx, act, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Vector table
    // ------------------------------------------------------------------------
    typedef struct {
        logic        valid;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wr;
        logic        ready;
        logic        exp_accept;
        logic        exp_rvalid;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic [3:0]  exp_ram_wr;
    } vec_t;

    vec_t vecs [64];
    int   n_vec = 0;

    task automatic add(input logic v, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] w, input logic rdy, input logic acc,
                       input logic rv, input logic [31:0] rd, input logic er,
                       input logic [3:0] rw);
        vecs[n_vec].valid      = v;
        vecs[n_vec].addr       = a;
        vecs[n_vec].wdata      = d;
        vecs[n_vec].wr         = w;
        vecs[n_vec].ready      = rdy;
        vecs[n_vec].exp_accept = acc;
        vecs[n_vec].exp_rvalid = rv;
        vecs[n_vec].exp_rdata  = rd;
        vecs[n_vec].exp_err    = er;
        vecs[n_vec].exp_ram_wr = rw;
        n_vec++;
    endtask

    initial begin
        logic [31:0]   exp_addr_full;
        logic [AW-1:0] exp_addr;

        // --- Fill table: {inputs} -> {accept, rvalid, rdata, err, ram_wr} ---

        // Full-word write then read of the same word.
        // Write ack first, then the read data two cycles after the read fires.
        add(1, 32'h0001_0000, 32'hDEAD_BEEF, 4'hF, 1,  1, 0, 32'h0,         0, 4'hF);
        add(1, 32'h0001_0000, 32'h0,         4'h0, 1,  1, 0, 32'h0,         0, 4'h0);
        add(0, 32'h0,         32'h0,         4'h0, 1,  1, 1, 32'h0,         0, 4'h0);
        add(0, 32'h0,         32'h0,         4'h0, 1,  1, 1, 32'hDEAD_BEEF, 0, 4'h0);

        // Byte-lane merge: byte 1 of 0x11223344 replaced by 0xAB.
        // Back-to-back write, write, read.
        add(1, 32'h0000_0020, 32'h1122_3344, 4'hF, 1,  1, 0, 32'h0,         0, 4'hF);
        add(1, 32'h0000_0020, 32'h0000_AB00, 4'h2, 1,  1, 0, 32'h0,         0, 4'h2);
        add(1, 32'h0000_0020, 32'h0,         4'h0, 1,  1, 1, 32'h0,         0, 4'h0);
        add(0, 32'h0,         32'h0,         4'h0, 1,  1, 1, 32'h0,         0, 4'h0);
        add(0, 32'h0,         32'h0,         4'h0, 1,  1, 1, 32'h1122_AB44, 0, 4'h0);
        add(0, 32'h0,         32'h0,         4'h0, 1,  1, 0, 32'h0,         0, 4'h0);

        // Backpressure: ready low, 3 back-to-back reads. Only 2 are taken.
        // The 3rd is accepted in the first pop cycle, and the responses
        // drain in order.
        add(1, 32'h0000_0100, 32'h0, 4'h0, 0,  1, 0, 32'h0,         0, 4'h0);
        add(1, 32'h0000_0104, 32'h0, 4'h0, 0,  1, 0, 32'h0,         0, 4'h0);
        add(1, 32'h0000_0108, 32'h0, 4'h0, 0,  0, 1, 32'hC0DE_0040, 0, 4'h0);
        add(1, 32'h0000_0108, 32'h0, 4'h0, 0,  0, 1, 32'hC0DE_0040, 0, 4'h0);
        add(1, 32'h0000_0108, 32'h0, 4'h0, 1,  1, 1, 32'hC0DE_0040, 0, 4'h0);
        add(0, 32'h0,         32'h0, 4'h0, 1,  1, 1, 32'hC0DE_0041, 0, 4'h0);
        add(0, 32'h0,         32'h0, 4'h0, 1,  1, 1, 32'hC0DE_0042, 0, 4'h0);
        add(0, 32'h0,         32'h0, 4'h0, 1,  1, 0, 32'h0,         0, 4'h0);

        // Streaming: 8 consecutive reads with ready high.
        // Responses arrive in consecutive cycles.
        for (int k = 0; k < 11; k++) begin
            add(k < 8, (k < 8) ? 32'h140 + 32'(4 * k) : 32'h0, 32'h0, 4'h0, 1,
                1, (k >= 2) && (k <= 9),
                ((k >= 2) && (k <= 9)) ? 32'hC0DE_0050 + 32'(k - 2) : 32'h0,
                0, 4'h0);
        end

        // Write above the RAM range. Without the range check it aliases to
        // word 0. With the range check it is blocked and flagged.
        add(1, 32'h8000_0000, 32'h5A5A_5A5A, 4'hF, 1,  1, 0, 32'h0, 0,
            RANGE_CHK ? 4'h0 : 4'hF);
        add(1, 32'h0000_0000, 32'h0,         4'h0, 1,  1, 0, 32'h0, 0, 4'h0);
        add(0, 32'h0,         32'h0,         4'h0, 1,  1, 1, 32'h0, RANGE_CHK, 4'h0);
        add(0, 32'h0,         32'h0,         4'h0, 1,  1, 1,
            RANGE_CHK ? 32'hC0DE_0000 : 32'h5A5A_5A5A, 0, 4'h0);
        add(0, 32'h0,         32'h0,         4'h0, 1,  1, 0, 32'h0, 0, 4'h0);

        // --- Reset values ---
        rst_i        = 1'b0;
        req_valid_i  = 1'b0;
        req_addr_i   = 32'h0;
        req_wdata_i  = 32'h0;
        req_wr_i     = 4'h0;
        resp_ready_i = 1'b0;

        @(negedge clk_i);
        check("rst_accept", 0, 32'(req_accept_o), 32'd1);
        check("rst_rvalid", 0, 32'(resp_valid_o), 32'd0);
        check("rst_rdata",  0, resp_rdata_o,      32'd0);
        check("rst_err",    0, 32'(resp_error_o), 32'd0);
        check("rst_ram_wr", 0, 32'(ram_wr_o),     32'd0);
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b1;

        @(negedge clk_i);
        check("post_rst_accept", 0, 32'(req_accept_o), 32'd1);
        check("post_rst_rvalid", 0, 32'(resp_valid_o), 32'd0);

        // --- Table-driven section ---
        for (int i = 0; i < n_vec; i++) begin
            @(posedge clk_i);
            #1;
            req_valid_i  = vecs[i].valid;
            req_addr_i   = vecs[i].addr;
            req_wdata_i  = vecs[i].wdata;
            req_wr_i     = vecs[i].wr;
            resp_ready_i = vecs[i].ready;

            @(negedge clk_i);
            exp_addr_full = vecs[i].addr >> 2;
            exp_addr      = exp_addr_full[AW-1:0];
            $display("vec %0d: v=%0b addr=%08h wr=%h rdy=%0b | acc=%0b rv=%0b rdata=%08h err=%0b ram_wr=%h",
                     i, vecs[i].valid, vecs[i].addr, vecs[i].wr, vecs[i].ready,
                     req_accept_o, resp_valid_o, resp_rdata_o, resp_error_o, ram_wr_o);

            check("accept",   i, 32'(req_accept_o), 32'(vecs[i].exp_accept));
            check("rvalid",   i, 32'(resp_valid_o), 32'(vecs[i].exp_rvalid));
            check("ram_wr",   i, 32'(ram_wr_o),     32'(vecs[i].exp_ram_wr));
            check("ram_addr", i, 32'(ram_addr_o),   32'(exp_addr));
            if (vecs[i].exp_rvalid) begin
                check("rdata", i, resp_rdata_o,      vecs[i].exp_rdata);
                check("err",   i, 32'(resp_error_o), 32'(vecs[i].exp_err));
            end
        end

        // --- Reset during an in-flight read ---
        @(posedge clk_i);
        #1;
        req_valid_i  = 1'b1;
        req_addr_i   = 32'h0000_0100;
        req_wr_i     = 4'h0;
        resp_ready_i = 1'b1;
        @(negedge clk_i);
        check("mid_rst_fire_accept", 100, 32'(req_accept_o), 32'd1);
        $display("mid-reset: read 0x100 issued, acc=%0b", req_accept_o);

        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        rst_i       = 1'b0;
        @(negedge clk_i);
        check("mid_rst_rvalid", 101, 32'(resp_valid_o), 32'd0);

        @(posedge clk_i);
        #1 rst_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_i);
            $display("after reset cycle %0d: acc=%0b rv=%0b", c, req_accept_o, resp_valid_o);
            check("after_rst_rvalid", 102 + c, 32'(resp_valid_o), 32'd0);
            check("after_rst_accept", 102 + c, 32'(req_accept_o), 32'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
